// File: rtl/ntru_pkg.sv
// Shared NTRU-HRSS parameters and the Rq0 unpack sequencer state type.
package ntru_pkg;

  localparam int unsigned N_DEF    = 701;
  localparam int unsigned LOGQ_DEF = 13;

  function automatic int unsigned nbytes(input int unsigned n, input int unsigned logq);
    return ((n - 1) * logq + 7) / 8;
  endfunction

  localparam int unsigned NBYTES_DEF = nbytes(N_DEF, LOGQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_FINAL,
    ST_DONE
  } rq0_state_e;

endpackage

// File: rtl/rq0_sum_acc.sv
// Running mod-2^LOGQ coefficient sum; exposes its two's-complement negation.
module rq0_sum_acc
  import ntru_pkg::*;
#(
  parameter int unsigned LOGQ = LOGQ_DEF
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [LOGQ-1:0] i_coef,
  output logic [LOGQ-1:0] o_neg
);

  logic [LOGQ-1:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_coef;
    end
  end

  assign o_neg = ~r_sum + LOGQ'(1);

endmodule

// File: rtl/unpack_rq0_ctrl.sv
// Rq0 unpacker: byte stream of packed LSB-first coefficients in, N coefficients out,
// with the last one synthesised as the negated sum of the others.
module unpack_rq0_ctrl
  import ntru_pkg::*;
#(
  parameter  int unsigned N      = N_DEF,
  parameter  int unsigned LOGQ   = LOGQ_DEF,
  localparam int unsigned NBYTES = nbytes(N, LOGQ),
  localparam int unsigned IDXW   = $clog2(N)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [LOGQ-1:0] out_coef,
  output logic [IDXW-1:0] out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            done,
  output logic            pad_err
);

  localparam int unsigned BUFW = LOGQ + 7;
  localparam int unsigned BCW  = $clog2(BUFW + 1);
  localparam int unsigned BYW  = $clog2(NBYTES + 1);

  localparam logic [BCW-1:0]  BC_Q      = BCW'(LOGQ);
  localparam logic [BYW-1:0]  BY_MAX    = BYW'(NBYTES);
  localparam logic [IDXW-1:0] IDX_LASTD = IDXW'(N - 2);
  localparam logic [IDXW-1:0] IDX_FINAL = IDXW'(N - 1);

  rq0_state_e       r_state;
  rq0_state_e       w_next;
  logic [BUFW-1:0]  r_buf;
  logic [BCW-1:0]   r_bc;
  logic [BYW-1:0]   r_bytes;
  logic [IDXW-1:0]  r_idx;
  logic             r_pad_err;

  logic             w_clr;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [LOGQ-1:0]  w_neg;

  assign w_in_fire  = (r_state == ST_UNPACK) && (r_bc < BC_Q) && (r_bytes < BY_MAX) && in_valid;
  assign w_out_fire = (r_state == ST_UNPACK) && (r_bc >= BC_Q) && out_ready;
  assign pad_err    = r_pad_err;

  rq0_sum_acc #(
    .LOGQ (LOGQ)
  ) u_sum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_out_fire),
    .i_coef (r_buf[LOGQ-1:0]),
    .o_neg  (w_neg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_coef  = '0;
    out_idx   = '0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_UNPACK;
          w_clr  = 1'b1;
        end
      end
      ST_UNPACK: begin
        busy      = 1'b1;
        in_ready  = (r_bc < BC_Q) && (r_bytes < BY_MAX);
        out_valid = (r_bc >= BC_Q);
        out_coef  = r_buf[LOGQ-1:0];
        out_idx   = r_idx;
        if (w_out_fire && (r_idx == IDX_LASTD)) begin
          w_next = ST_FINAL;
        end
      end
      ST_FINAL: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_coef  = w_neg;
        out_idx   = IDX_FINAL;
        if (out_ready) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bits above r_bc are always zero, so the padding check is a plain OR of the leftovers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf     <= '0;
      r_bc      <= '0;
      r_bytes   <= '0;
      r_idx     <= '0;
      r_pad_err <= 1'b0;
    end else if (w_clr) begin
      r_buf     <= '0;
      r_bc      <= '0;
      r_bytes   <= '0;
      r_idx     <= '0;
      r_pad_err <= 1'b0;
    end else if (w_in_fire) begin
      r_buf   <= r_buf | (BUFW'(in_data) << r_bc);
      r_bc    <= r_bc + BCW'(8);
      r_bytes <= r_bytes + 1'b1;
    end else if (w_out_fire) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == IDX_LASTD) begin
        r_buf <= '0;
        r_bc  <= '0;
        if (|r_buf[BUFW-1:LOGQ]) begin
          r_pad_err <= 1'b1;
        end
      end else begin
        r_buf <= r_buf >> LOGQ;
        r_bc  <= r_bc - BC_Q;
      end
    end
  end

endmodule

// File: tb/tb_unpack_rq0_ctrl.sv
// Directed bench for unpack_rq0_ctrl: a 4-coefficient instance and a full-size instance.
module tb_unpack_rq0_ctrl;

  localparam int NS   = 4;
  localparam int NB_S = 5;
  localparam int NL   = 701;
  localparam int NB_L = 1138;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        s_start, s_in_valid, s_out_ready;
  logic [7:0]  s_in_data;
  logic        s_busy, s_in_ready, s_out_valid, s_out_last, s_done, s_pad_err;
  logic [12:0] s_out_coef;
  logic [1:0]  s_out_idx;

  logic        b_start, b_in_valid, b_out_ready;
  logic [7:0]  b_in_data;
  logic        b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_pad_err;
  logic [12:0] b_out_coef;
  logic [9:0]  b_out_idx;

  int tests = 0;
  int fails = 0;

  logic [7:0]  s_bytes [NB_S];
  logic [7:0]  l_bytes [NB_L];
  logic [12:0] l_exp   [NL];

  unpack_rq0_ctrl #(.N(NS), .LOGQ(13)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_coef(s_out_coef), .out_idx(s_out_idx), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_last(s_out_last), .done(s_done), .pad_err(s_pad_err)
  );

  unpack_rq0_ctrl #(.N(NL), .LOGQ(13)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_coef(b_out_coef), .out_idx(b_out_idx), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .done(b_done), .pad_err(b_pad_err)
  );

  // Reference unpacking by absolute bit position, independent of any shift register.
  task automatic model_big();
    logic [12:0] c;
    logic [12:0] sum;
    logic [7:0]  by;
    int          pos;
    sum = '0;
    for (int k = 0; k < NL - 1; k++) begin
      c = '0;
      for (int b = 0; b < 13; b++) begin
        pos  = k * 13 + b;
        by   = l_bytes[pos / 8];
        c[b] = by[pos % 8];
      end
      l_exp[k] = c;
      sum = sum + c;
    end
    l_exp[NL-1] = 13'd0 - sum;
  endtask

  task automatic run_small(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic exp_pad);
    logic [12:0] exp_c [NS];
    int ptr, k, cyc, ndone, post, first_valid;
    bit fi, fo, pad_chk, fin;
    s_bytes[0] = b0; s_bytes[1] = b1; s_bytes[2] = b2; s_bytes[3] = b3; s_bytes[4] = b4;
    exp_c[0] = 13'h0001; exp_c[1] = 13'h0002; exp_c[2] = 13'h0003; exp_c[3] = 13'h1FFA;
    ptr = 0; k = 0; cyc = 0; ndone = 0; post = 0; first_valid = 0; pad_chk = 0; fin = 0;
    @(posedge clk); #1;
    s_start = 1'b1; s_in_data = s_bytes[0]; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      fi = s_in_valid && s_in_ready;
      fo = s_out_valid && s_out_ready;
      if (cyc == 1) begin
        tests++;
        if (s_busy !== 1'b1 || s_pad_err !== 1'b0) begin
          fails++;
          $display("FAIL small_start: busy=%b pad_err=%b, want busy=1 pad_err=0", s_busy, s_pad_err);
        end
      end
      if (s_out_valid && first_valid == 0) first_valid = cyc;
      if (pad_chk) begin
        pad_chk = 0;
        tests++;
        if (s_pad_err !== exp_pad) begin
          fails++;
          $display("FAIL small_pad_err: got %b want %b", s_pad_err, exp_pad);
        end
      end
      if (s_done) begin
        ndone++;
        tests++;
        if (k != NS) begin
          fails++;
          $display("FAIL small_done_timing: done after %0d handshakes, want %0d", k, NS);
        end
      end
      if (fo) begin
        tests++;
        if (k >= NS) begin
          fails++;
          $display("FAIL small_extra_out: got idx %0d after run end", s_out_idx);
        end else if (s_out_coef !== exp_c[k] || s_out_idx !== 2'(k) || s_out_last !== (k == NS - 1)) begin
          fails++;
          $display("FAIL small_coef[%0d]: got %h idx %0d last %b, want %h idx %0d last %b",
                   k, s_out_coef, s_out_idx, s_out_last, exp_c[k], k, (k == NS - 1));
        end
        if (k == NS - 2) pad_chk = 1;
        k++;
      end
      @(posedge clk); #1;
      if (fi) ptr++;
      s_in_valid = (ptr < NB_S);
      s_in_data  = (ptr < NB_S) ? s_bytes[ptr] : 8'h00;
      if (ndone > 0) begin
        post++;
        if (post == 3) fin = 1;
      end
    end
    s_in_valid = 1'b0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL small_timeout: run did not finish in %0d cycles", cyc);
    end
    tests++;
    if (ndone != 1 || k != NS) begin
      fails++;
      $display("FAIL small_counts: done pulses %0d handshakes %0d, want 1 and %0d", ndone, k, NS);
    end
    tests++;
    if (first_valid != 3) begin
      fails++;
      $display("FAIL small_latency: first out_valid at cycle %0d, want 3", first_valid);
    end
    tests++;
    if (s_busy !== 1'b0 || s_pad_err !== exp_pad) begin
      fails++;
      $display("FAIL small_after: busy=%b pad_err=%b, want 0 and %b", s_busy, s_pad_err, exp_pad);
    end
  endtask

  task automatic run_big(input int gin, input int gout, input int stall_at,
                         input int abort_at, input int pulse_at);
    int ptr, k, cyc, ndone, post, stall_cnt;
    bit fi, fo, aborted, pulsed, fin;
    ptr = 0; k = 0; cyc = 0; ndone = 0; post = 0; stall_cnt = 0;
    aborted = 0; pulsed = 0; fin = 0;
    @(posedge clk); #1;
    b_start = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_in_data = l_bytes[0]; b_in_valid = 1'b1;
    tests++;
    if (b_busy !== 1'b1) begin
      fails++;
      $display("FAIL big_busy_after_start: got %b want 1", b_busy);
    end
    while (!fin && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      fi = b_in_valid && b_in_ready;
      fo = b_out_valid && b_out_ready;
      if (b_out_valid && !b_out_ready && k == stall_at) begin
        stall_cnt++;
        tests++;
        if (b_out_coef !== l_exp[k] || b_out_idx !== 10'(k) || b_in_ready !== 1'b0) begin
          fails++;
          $display("FAIL big_stall: coef %h idx %0d in_ready %b, want %h idx %0d in_ready 0",
                   b_out_coef, b_out_idx, b_in_ready, l_exp[k], k);
        end
      end
      if (b_done) begin
        ndone++;
        tests++;
        if (k != NL) begin
          fails++;
          $display("FAIL big_done_timing: done after %0d handshakes, want %0d", k, NL);
        end
      end
      if (fo) begin
        tests++;
        if (k >= NL) begin
          fails++;
          $display("FAIL big_extra_out: got idx %0d after run end", b_out_idx);
        end else if (b_out_coef !== l_exp[k] || b_out_idx !== 10'(k) || b_out_last !== (k == NL - 1)) begin
          fails++;
          $display("FAIL big_coef[%0d]: got %h idx %0d last %b, want %h idx %0d last %b",
                   k, b_out_coef, b_out_idx, b_out_last, l_exp[k], k, (k == NL - 1));
        end
        k++;
      end
      @(posedge clk); #1;
      if (fi) ptr++;
      b_in_data   = (ptr < NB_L) ? l_bytes[ptr] : 8'h00;
      b_in_valid  = (ptr < NB_L) && ($urandom_range(99) >= gin);
      b_out_ready = ($urandom_range(99) >= gout) && !(k == stall_at && stall_cnt < 5);
      b_start     = (k == pulse_at) && !pulsed;
      if (b_start) pulsed = 1;
      if (abort_at >= 0 && k == abort_at + 1) begin
        rst = 1'b0;
        #1;
        tests++;
        if ({b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_pad_err} !== 6'b0 ||
            b_out_coef !== 13'h0 || b_out_idx !== 10'h0) begin
          fails++;
          $display("FAIL big_abort_outputs: busy %b in_rdy %b valid %b last %b done %b pad %b coef %h idx %0d, want all 0",
                   b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_pad_err, b_out_coef, b_out_idx);
        end
        aborted = 1;
        fin = 1;
      end
      if (ndone > 0) begin
        post++;
        if (post == 4) fin = 1;
      end
    end
    b_in_valid = 1'b0;
    b_start    = 1'b0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL big_timeout: run did not finish in %0d cycles", cyc);
    end
    if (aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        tests++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
          fails++;
          $display("FAIL big_abort_quiet: done %b busy %b, want 0 0", b_done, b_busy);
        end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      tests++;
      if (ndone != 0) begin
        fails++;
        $display("FAIL big_abort_done: %0d done pulses, want 0", ndone);
      end
    end else begin
      tests++;
      if (ndone != 1 || k != NL) begin
        fails++;
        $display("FAIL big_counts: done pulses %0d handshakes %0d, want 1 and %0d", ndone, k, NL);
      end
      tests++;
      if (b_busy !== 1'b0 || b_pad_err !== 1'b0) begin
        fails++;
        $display("FAIL big_after: busy %b pad_err %b, want 0 0", b_busy, b_pad_err);
      end
      if (stall_at >= 0) begin
        tests++;
        if (stall_cnt != 5) begin
          fails++;
          $display("FAIL big_stall_len: %0d stalled cycles seen, want 5", stall_cnt);
        end
      end
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NB_L; i++) l_bytes[i] = 8'((i * 73 + 11) & 255);
    l_bytes[NB_L-1] = l_bytes[NB_L-1] & 8'h0F;
    model_big();
  endtask

  task automatic test_reset();
    s_start = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({s_busy, s_in_ready, s_out_valid, s_out_last, s_done, s_pad_err} !== 6'b0 ||
        s_out_coef !== 13'h0 || s_out_idx !== 2'h0) begin
      fails++;
      $display("FAIL reset_small: busy %b in_rdy %b valid %b last %b done %b pad %b coef %h idx %0d, want all 0",
               s_busy, s_in_ready, s_out_valid, s_out_last, s_done, s_pad_err, s_out_coef, s_out_idx);
    end
    tests++;
    if ({b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_pad_err} !== 6'b0 ||
        b_out_coef !== 13'h0 || b_out_idx !== 10'h0) begin
      fails++;
      $display("FAIL reset_big: busy %b in_rdy %b valid %b last %b done %b pad %b coef %h idx %0d, want all 0",
               b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_pad_err, b_out_coef, b_out_idx);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_small(8'h01, 8'h40, 8'h00, 8'h0C, 8'h00, 1'b0);
  endtask

  task automatic test_pad_err();
    run_small(8'h01, 8'h40, 8'h00, 8'h0C, 8'h80, 1'b1);
    run_small(8'h01, 8'h40, 8'h00, 8'h0C, 8'h00, 1'b0);
  endtask

  task automatic test_full_size();
    for (int i = 0; i < NB_L - 1; i++) l_bytes[i] = 8'hFF;
    l_bytes[NB_L-1] = 8'h0F;
    for (int k = 0; k < NL - 1; k++) l_exp[k] = 13'h1FFF;
    l_exp[NL-1] = 13'h02BC;
    run_big(0, 0, -1, -1, -1);
  endtask

  task automatic test_backpressure();
    fill_pattern();
    run_big(0, 0, 10, -1, -1);
    run_big(30, 30, -1, -1, -1);
  endtask

  task automatic test_reset_mid_run();
    fill_pattern();
    run_big(0, 0, -1, 200, -1);
    run_big(0, 0, -1, -1, -1);
  endtask

  task automatic test_start_while_busy();
    fill_pattern();
    run_big(10, 10, -1, -1, 50);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad_err();
    test_full_size();
    test_backpressure();
    test_reset_mid_run();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
